// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Dual-issue front end. Fetch pairs go into a circular queue;
//               0, 1 or 2 insts are issued per cycle, and issue is held
//               after a branch until br_resolve.
//               Optional build macro ISSUE_STATS_EN adds issue counters.
// Revision    : 1.0
// ============================================================================
module issue_scheduler #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_data,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        br_resolve,
  input  logic        issue_ready,
  output logic        issue0_valid,
  output logic [31:0] issue0_inst,
  output logic        issue1_valid,
  output logic [31:0] issue1_inst,
  output logic [AW:0] count
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] stat_dual,
  output logic [31:0] stat_single
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

  localparam logic [AW:0] c_ready_max = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] c_two       = (AW+1)'(2);

  logic [31:0]   r_q [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic          r_v0;
  logic          r_v1;
  logic [31:0]   r_i0;
  logic [31:0]   r_i1;

  // PowerPC numbers bits from the MSB, so OP=[0:5] lands in [31:26].
  function automatic logic f_is_br(input logic [5:0] op);
    return (op == 6'd16) || (op == 6'd18) || (op == 6'd19);
  endfunction

  function automatic logic f_is_wr(input logic [5:0] op);
    return !f_is_br(op) &&
           !((op == 6'd36) || (op == 6'd37) || (op == 6'd38) || (op == 6'd39) ||
             (op == 6'd44) || (op == 6'd45) || (op == 6'd62));
  endfunction

  logic [AW-1:0] w_head1;
  logic [31:0]   w_q0;
  logic [31:0]   w_q1;
  logic [5:0]    w_op0;
  logic [4:0]    w_rt0;
  logic [5:0]    w_op1;
  logic [4:0]    w_rt1;
  logic [4:0]    w_ra1;
  logic [4:0]    w_rb1;
  logic          w_br0;
  logic          w_hazard;
  logic          w_dual;
  logic          w_load;
  logic          w_empty;
  logic [1:0]    w_pop;
  logic          w_push;
  logic [AW:0]   w_count_nxt;

  assign w_head1  = r_head + AW'(1);
  assign w_q0     = r_q[r_head];
  assign w_q1     = r_q[w_head1];
  assign w_op0    = w_q0[31:26];
  assign w_rt0    = w_q0[25:21];
  assign w_op1    = w_q1[31:26];
  assign w_rt1    = w_q1[25:21];
  assign w_ra1    = w_q1[20:16];
  assign w_rb1    = w_q1[15:11];
  assign w_br0    = f_is_br(w_op0);
  assign w_hazard = f_is_wr(w_op0) &&
                    ((w_ra1 == w_rt0) || (w_rb1 == w_rt0) ||
                     (f_is_wr(w_op1) && (w_rt1 == w_rt0)));
  assign w_dual   = (r_count >= c_two) && !w_br0 && !f_is_br(w_op1) && !w_hazard;
  assign w_load   = (r_state == RUN) && (!r_v0 || issue_ready);
  assign w_empty  = (r_count == '0);
  assign w_pop    = (w_load && !w_empty) ? (w_dual ? 2'd2 : 2'd1) : 2'd0;
  assign w_push   = fetch_valid && fetch_ready;
  assign w_count_nxt = r_count + (w_push ? c_two : '0) - (AW+1)'(w_pop);

  assign fetch_ready  = (r_count <= c_ready_max);
  assign issue0_valid = r_v0;
  assign issue0_inst  = r_i0;
  assign issue1_valid = r_v1;
  assign issue1_inst  = r_i1;
  assign count        = r_count;

  // Queue storage carries no reset; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q[r_tail]          <= fetch_data[63:32];
      r_q[r_tail + AW'(1)] <= fetch_data[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= RUN;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_i0    <= '0;
      r_i1    <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= RUN;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(2);
      r_head  <= r_head + AW'(w_pop);
      r_count <= w_count_nxt;
      case (r_state)
        RUN: begin
          if (w_load) begin
            if (w_empty) begin
              r_v0 <= 1'b0;
              r_v1 <= 1'b0;
            end else begin
              r_v0 <= 1'b1;
              r_i0 <= w_q0;
              r_v1 <= w_dual;
              r_i1 <= w_dual ? w_q1 : '0;
              if (w_br0) r_state <= BR_WAIT;
            end
          end
        end
        BR_WAIT: begin
          // Branch leaves once accepted; nothing reloads until resolved.
          if (issue_ready && r_v0) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
          end
          if (br_resolve) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] r_stat_dual;
  logic [31:0] r_stat_single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_dual   <= '0;
      r_stat_single <= '0;
    end else if (issue_ready && r_v0) begin
      if (r_v1) r_stat_dual   <= r_stat_dual + 32'd1;
      else      r_stat_single <= r_stat_single + 32'd1;
    end
  end

  assign stat_dual   = r_stat_dual;
  assign stat_single = r_stat_single;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// Testbench for issue_scheduler: expected issue groups are queued as stimulus
// is driven and matched against groups the DUT hands downstream.
module tb_issue_scheduler;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic        fetch_ready;
  logic        flush;
  logic        br_resolve;
  logic        issue_ready;
  logic        issue0_valid;
  logic [31:0] issue0_inst;
  logic        issue1_valid;
  logic [31:0] issue1_inst;
  logic [AW:0] count;

  typedef struct packed {
    logic        v1;
    logic [31:0] i0;
    logic [31:0] i1;
  } grp_t;

  grp_t sb[$];
  grp_t obs[$];
  int   total = 0;
  int   bad = 0;
  int   slot_viol = 0;

  issue_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .flush(flush), .br_resolve(br_resolve), .issue_ready(issue_ready),
    .issue0_valid(issue0_valid), .issue0_inst(issue0_inst),
    .issue1_valid(issue1_valid), .issue1_inst(issue1_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  // Records the group accepted at the coming edge, then advances one cycle.
  task automatic tick();
    grp_t g;
    if (issue1_valid && !issue0_valid) slot_viol++;
    if (issue_ready && issue0_valid) begin
      g.v1 = issue1_valid;
      g.i0 = issue0_inst;
      g.i1 = issue1_valid ? issue1_inst : 32'h0;
      obs.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    fetch_valid = 1'b1;
    fetch_data  = {a, b};
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic exp_grp(input logic v1, input logic [31:0] a, input logic [31:0] b);
    grp_t g;
    g.v1 = v1;
    g.i0 = a;
    g.i1 = b;
    sb.push_back(g);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0;
    br_resolve = 1'b0; issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (issue0_valid !== 1'b0) begin bad++; $display("FAIL rst_v0: got %b required 0", issue0_valid); end
    total++; if (issue1_valid !== 1'b0) begin bad++; $display("FAIL rst_v1: got %b required 0", issue1_valid); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", count); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_fready: got %b required 1", fetch_ready); end
    total++; if (issue0_inst !== 32'h0) begin bad++; $display("FAIL rst_inst0: got %h required 0", issue0_inst); end
    rst_n = 1'b1;
    // Leave a branch in the issue regs (BR_WAIT), then reset asynchronously.
    push_pair(32'h48000010, 32'h38610001);
    tick();
    total++; if (issue0_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_load: got %b required 1", issue0_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (issue0_valid !== 1'b0) begin bad++; $display("FAIL arst_v0: got %b required 0", issue0_valid); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL arst_count: got %0d required 0", count); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL arst_fready: got %b required 1", fetch_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
    sb.delete();
  endtask

  task automatic test_dual();
    grp_t e, g;
    issue_ready = 1'b1;
    push_pair(32'h38610001, 32'h38820001);
    total++; if (count !== 7'd2) begin bad++; $display("FAIL dual_cnt_T: got %0d required 2", count); end
    total++; if (issue0_valid !== 1'b0) begin bad++; $display("FAIL dual_early: got %b required 0", issue0_valid); end
    tick();
    total++; if (issue0_valid !== 1'b1 || issue1_valid !== 1'b1) begin bad++; $display("FAIL dual_valids: got %b%b required 11", issue0_valid, issue1_valid); end
    total++; if (issue0_inst !== 32'h38610001) begin bad++; $display("FAIL dual_inst0: got %h required 38610001", issue0_inst); end
    total++; if (issue1_inst !== 32'h38820001) begin bad++; $display("FAIL dual_inst1: got %h required 38820001", issue1_inst); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL dual_cnt: got %0d required 0", count); end
    exp_grp(1'b1, 32'h38610001, 32'h38820001);
    repeat (3) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs.size() == 0) begin
        bad++; $display("FAIL dual_sb: got nothing required v1=%b i0=%h i1=%h", e.v1, e.i0, e.i1);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin bad++; $display("FAIL dual_sb: got v1=%b i0=%h i1=%h required v1=%b i0=%h i1=%h", g.v1, g.i0, g.i1, e.v1, e.i0, e.i1); end
      end
    end
  endtask

  task automatic test_raw();
    grp_t e, g;
    issue_ready = 1'b1;
    push_pair(32'h38610001, 32'h7CA32214);
    exp_grp(1'b0, 32'h38610001, 32'h0);
    exp_grp(1'b0, 32'h7CA32214, 32'h0);
    repeat (5) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs.size() == 0) begin
        bad++; $display("FAIL raw_sb: got nothing required v1=%b i0=%h", e.v1, e.i0);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin bad++; $display("FAIL raw_sb: got v1=%b i0=%h i1=%h required v1=%b i0=%h i1=%h", g.v1, g.i0, g.i1, e.v1, e.i0, e.i1); end
      end
    end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL raw_extra: got %0d extra groups required 0", obs.size()); obs.delete(); end
  endtask

  task automatic test_branch();
    grp_t e, g;
    int n;
    issue_ready = 1'b1;
    push_pair(32'h48000010, 32'h38610001);
    exp_grp(1'b0, 32'h48000010, 32'h0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (issue0_valid !== 1'b0) begin bad++; $display("FAIL br_wait_%0d: got v0=%b required 0", i, issue0_valid); end
      tick();
    end
    total++; if (count !== 7'd1) begin bad++; $display("FAIL br_count: got %0d required 1", count); end
    br_resolve = 1'b1;
    tick();
    br_resolve = 1'b0;
    n = 0;
    while (!issue0_valid && n < 4) begin tick(); n++; end
    total++; if (issue0_valid !== 1'b1) begin bad++; $display("FAIL br_resume: got v0=%b required 1 (timeout)", issue0_valid); end
    exp_grp(1'b0, 32'h38610001, 32'h0);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs.size() == 0) begin
        bad++; $display("FAIL br_sb: got nothing required v1=%b i0=%h", e.v1, e.i0);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin bad++; $display("FAIL br_sb: got v1=%b i0=%h i1=%h required v1=%b i0=%h i1=%h", g.v1, g.i0, g.i1, e.v1, e.i0, e.i1); end
      end
    end
  endtask

  task automatic test_backpressure();
    grp_t e, g;
    issue_ready = 1'b0;
    for (int k = 0; k < 33; k++) begin
      fetch_valid = 1'b1;
      fetch_data  = {32'h38610000 + 32'(k), 32'h38820000 + 32'(k)};
      exp_grp(1'b1, 32'h38610000 + 32'(k), 32'h38820000 + 32'(k));
      tick();
    end
    fetch_data = {32'h38610021, 32'h38820021};
    repeat (2) tick();
    fetch_valid = 1'b0;
    total++; if (count !== 7'd64) begin bad++; $display("FAIL bp_count: got %0d required 64", count); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL bp_fready: got %b required 0", fetch_ready); end
    total++; if (issue0_inst !== 32'h38610000 || issue1_valid !== 1'b1) begin bad++; $display("FAIL bp_hold: got i0=%h v1=%b required i0=38610000 v1=1", issue0_inst, issue1_valid); end
    issue_ready = 1'b1;
    repeat (40) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs.size() == 0) begin
        bad++; $display("FAIL bp_sb: got nothing required v1=%b i0=%h i1=%h", e.v1, e.i0, e.i1);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin bad++; $display("FAIL bp_sb: got v1=%b i0=%h i1=%h required v1=%b i0=%h i1=%h", g.v1, g.i0, g.i1, e.v1, e.i0, e.i1); end
      end
    end
    total++; if (obs.size() != 0) begin bad++; $display("FAIL bp_extra: got %0d extra groups required 0", obs.size()); obs.delete(); end
    total++; if (count !== 7'd0) begin bad++; $display("FAIL bp_drain: got count %0d required 0", count); end
  endtask

  task automatic test_flush();
    grp_t e, g;
    int n;
    issue_ready = 1'b1;
    push_pair(32'h38610001, 32'h48000010);
    exp_grp(1'b0, 32'h38610001, 32'h0);
    exp_grp(1'b0, 32'h48000010, 32'h0);
    fetch_valid = 1'b1;
    fetch_data  = {32'h38610002, 32'h38820002};
    tick();
    fetch_data  = {32'h38610003, 32'h38820003};
    tick();
    fetch_data  = {32'h38610004, 32'h38820004};
    tick();
    total++; if (count !== 7'd6 || issue0_valid !== 1'b0) begin bad++; $display("FAIL fl_setup: got count=%0d v0=%b required 6/0", count, issue0_valid); end
    fetch_data = {32'h38610009, 32'h38820009};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    total++; if (count !== 7'd0) begin bad++; $display("FAIL fl_count: got %0d required 0", count); end
    total++; if (issue0_valid !== 1'b0 || issue1_valid !== 1'b0) begin bad++; $display("FAIL fl_valids: got %b%b required 00", issue0_valid, issue1_valid); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL fl_fready: got %b required 1", fetch_ready); end
    push_pair(32'h38610005, 32'h38820005);
    exp_grp(1'b1, 32'h38610005, 32'h38820005);
    n = 0;
    while (!issue0_valid && n < 4) begin tick(); n++; end
    total++; if (issue0_valid !== 1'b1) begin bad++; $display("FAIL fl_run: got v0=%b required 1 (timeout)", issue0_valid); end
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs.size() == 0) begin
        bad++; $display("FAIL fl_sb: got nothing required v1=%b i0=%h i1=%h", e.v1, e.i0, e.i1);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin bad++; $display("FAIL fl_sb: got v1=%b i0=%h i1=%h required v1=%b i0=%h i1=%h", g.v1, g.i0, g.i1, e.v1, e.i0, e.i1); end
      end
    end
  endtask

  task automatic test_slot_order();
    total++; if (slot_viol != 0) begin bad++; $display("FAIL slot_order: got %0d cycles with v1 && !v0 required 0", slot_viol); end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_raw();
    test_branch();
    test_backpressure();
    test_flush();
    test_slot_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
